// File: rtl/hiv1_assay_sequencer.sv
// Timed sequencer for one HIV-1 p24 immunoassay run: drives the flow switch
// port selects plus pump/mixer enables through load, mix, capture, washes, detect and flush.
module hiv1_assay_sequencer #(
  parameter int TIMER_W   = 16,
  parameter int T_LOAD    = 64,
  parameter int T_MIX     = 256,
  parameter int T_XFER    = 32,
  parameter int T_WASH    = 48,
  parameter int WASH_REPS = 2,
  parameter int T_DET     = 128,
  parameter int T_FLUSH   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       hold,
  input  logic       fault,
  output logic [1:0] sw41_sel,
  output logic [1:0] sw42_sel,
  output logic [1:0] sw3_sel,
  output logic       flow_en,
  output logic       mix_en,
  output logic       detect_valid,
  output logic [3:0] step,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  if (T_LOAD < 1 || T_MIX < 1 || T_XFER < 1 || T_WASH < 1 || T_DET < 1 || T_FLUSH < 1 ||
      WASH_REPS < 1 || WASH_REPS > 15) begin : g_bad_param
    $error("hiv1_assay_sequencer: zero duration or WASH_REPS outside 1..15");
  end

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_MIX       = 4'd2,
    S_CAPTURE   = 4'd3,
    S_WASH_A    = 4'd4,
    S_ANTIBODY  = 4'd5,
    S_WASH_B    = 4'd6,
    S_SUBSTRATE = 4'd7,
    S_DETECT    = 4'd8,
    S_FLUSH     = 4'd9,
    S_FAULT     = 4'd15
  } state_t;

  state_t             state, nxt_state;
  logic [TIMER_W-1:0] timer, nxt_timer;
  logic [3:0]         wash_cnt, nxt_wash;
  logic               paused, abort_go, run_end;
  logic [1:0]         nxt_sw41, nxt_sw42, nxt_sw3;
  logic               nxt_flow, nxt_mix;

  // Next state and timer; priority is fault, then abort, then hold, then expiry.
  always_comb begin
    nxt_state = state;
    nxt_timer = timer;
    nxt_wash  = wash_cnt;
    paused    = 1'b0;
    abort_go  = 1'b0;
    run_end   = 1'b0;
    if (fault) begin
      nxt_state = S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !hold) begin
            nxt_state = S_LOAD;
            nxt_timer = TIMER_W'(T_LOAD - 1);
          end
        end
        S_FAULT: ;
        default: begin
          if (abort && state != S_FLUSH) begin
            nxt_state = S_FLUSH;
            nxt_timer = TIMER_W'(T_FLUSH - 1);
            abort_go  = 1'b1;
          end else if (hold) begin
            paused = 1'b1;
          end else if (timer != '0) begin
            nxt_timer = timer - 1'b1;
          end else if ((state == S_WASH_A || state == S_WASH_B) &&
                       wash_cnt != 4'(WASH_REPS - 1)) begin
            nxt_wash  = wash_cnt + 4'd1;
            nxt_timer = TIMER_W'(T_WASH - 1);
          end else begin
            nxt_wash = '0;
            case (state)
              S_LOAD:      begin nxt_state = S_MIX;       nxt_timer = TIMER_W'(T_MIX - 1);   end
              S_MIX:       begin nxt_state = S_CAPTURE;   nxt_timer = TIMER_W'(T_XFER - 1);  end
              S_CAPTURE:   begin nxt_state = S_WASH_A;    nxt_timer = TIMER_W'(T_WASH - 1);  end
              S_WASH_A:    begin nxt_state = S_ANTIBODY;  nxt_timer = TIMER_W'(T_XFER - 1);  end
              S_ANTIBODY:  begin nxt_state = S_WASH_B;    nxt_timer = TIMER_W'(T_WASH - 1);  end
              S_WASH_B:    begin nxt_state = S_SUBSTRATE; nxt_timer = TIMER_W'(T_XFER - 1);  end
              S_SUBSTRATE: begin nxt_state = S_DETECT;    nxt_timer = TIMER_W'(T_DET - 1);   end
              S_DETECT:    begin nxt_state = S_FLUSH;     nxt_timer = TIMER_W'(T_FLUSH - 1); end
              S_FLUSH:     begin nxt_state = S_IDLE;      nxt_timer = '0; run_end = 1'b1;    end
              default:     begin nxt_state = S_FAULT;     nxt_timer = '0;                    end
            endcase
          end
        end
      endcase
    end
  end

  // Switch routing per state; selects depend only on the state so they never move mid-step.
  always_comb begin
    nxt_sw41 = 2'd1;
    nxt_sw42 = 2'd0;
    nxt_sw3  = 2'd2;
    nxt_flow = 1'b0;
    nxt_mix  = 1'b0;
    case (nxt_state)
      S_LOAD:      begin nxt_sw42 = 2'd3; nxt_sw3 = 2'd3; nxt_flow = 1'b1; end
      S_MIX:       nxt_mix = 1'b1;
      S_CAPTURE,
      S_WASH_A,
      S_WASH_B:    begin nxt_sw3 = 2'd1; nxt_flow = 1'b1; end
      S_ANTIBODY:  begin nxt_sw41 = 2'd2; nxt_sw42 = 2'd1; nxt_sw3 = 2'd1; nxt_flow = 1'b1; end
      S_SUBSTRATE: begin nxt_sw41 = 2'd0; nxt_sw42 = 2'd1; nxt_sw3 = 2'd1; nxt_flow = 1'b1; end
      S_DETECT:    begin nxt_sw41 = 2'd3; nxt_sw42 = 2'd1; nxt_sw3 = 2'd1; nxt_flow = 1'b1; end
      S_FLUSH:     begin nxt_sw3 = 2'd3; nxt_flow = 1'b1; end
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      wash_cnt     <= '0;
      sw41_sel     <= 2'd1;
      sw42_sel     <= 2'd0;
      sw3_sel      <= 2'd2;
      flow_en      <= 1'b0;
      mix_en       <= 1'b0;
      detect_valid <= 1'b0;
      step         <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= nxt_state;
      timer        <= nxt_timer;
      wash_cnt     <= nxt_wash;
      sw41_sel     <= nxt_sw41;
      sw42_sel     <= nxt_sw42;
      sw3_sel      <= nxt_sw3;
      flow_en      <= nxt_flow && !paused;
      mix_en       <= nxt_mix && !paused;
      detect_valid <= (nxt_state == S_DETECT) && !paused;
      step         <= nxt_state;
      busy         <= (nxt_state != S_IDLE) && (nxt_state != S_FAULT);
      done         <= run_end && !aborted;
      if (state == S_IDLE && nxt_state == S_LOAD)
        aborted <= 1'b0;
      else if (abort_go)
        aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hiv1_assay_sequencer.sv
// Scoreboard bench for hiv1_assay_sequencer: every change of the output vector
// is matched against a hand-computed expected event (cycle offset from start and values).
module tb_hiv1_assay_sequencer;

  logic       clk, rst, start, abort, hold, fault;
  logic [1:0] sw41Sel, sw42Sel, sw3Sel;
  logic       flowEn, mixEn, detectValid, busy, done, aborted;
  logic [3:0] step;
  logic [15:0] outVec;

  typedef struct {
    string       name;
    int          rel;
    logic [15:0] vec;
  } expEntry;

  expEntry expQ[$];
  int cycleCount = 0;
  int mark = 0;
  bit armed = 0;
  int compares = 0;
  int mismatches = 0;

  hiv1_assay_sequencer #(
    .TIMER_W(16), .T_LOAD(4), .T_MIX(4), .T_XFER(4), .T_WASH(4),
    .WASH_REPS(2), .T_DET(4), .T_FLUSH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold), .fault(fault),
    .sw41_sel(sw41Sel), .sw42_sel(sw42Sel), .sw3_sel(sw3Sel),
    .flow_en(flowEn), .mix_en(mixEn), .detect_valid(detectValid),
    .step(step), .busy(busy), .done(done), .aborted(aborted)
  );

  assign outVec = {step, sw41Sel, sw42Sel, sw3Sel, flowEn, mixEn, detectValid, busy, done, aborted};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Reference outputs for a state code, optionally with hold forcing the enables off.
  function automatic logic [15:0] mkVec(int code, bit pause, bit doneBit, bit abortedBit);
    logic [1:0] a, b, c;
    logic f, m, det, bsy;
    case (code)
      1:       begin a = 2'd1; b = 2'd3; c = 2'd3; f = 1'b1; m = 1'b0; end
      2:       begin a = 2'd1; b = 2'd0; c = 2'd2; f = 1'b0; m = 1'b1; end
      3, 4, 6: begin a = 2'd1; b = 2'd0; c = 2'd1; f = 1'b1; m = 1'b0; end
      5:       begin a = 2'd2; b = 2'd1; c = 2'd1; f = 1'b1; m = 1'b0; end
      7:       begin a = 2'd0; b = 2'd1; c = 2'd1; f = 1'b1; m = 1'b0; end
      8:       begin a = 2'd3; b = 2'd1; c = 2'd1; f = 1'b1; m = 1'b0; end
      9:       begin a = 2'd1; b = 2'd0; c = 2'd3; f = 1'b1; m = 1'b0; end
      default: begin a = 2'd1; b = 2'd0; c = 2'd2; f = 1'b0; m = 1'b0; end
    endcase
    if (pause) begin
      f = 1'b0;
      m = 1'b0;
    end
    det = (code == 8) && !pause;
    bsy = (code != 0) && (code != 15);
    return {4'(code), a, b, c, f, m, det, bsy, doneBit, abortedBit};
  endfunction

  task automatic expectEv(input string name, input int rel, input int code, input bit pause,
                          input bit doneBit, input bit abortedBit);
    expEntry e;
    e.name = name;
    e.rel  = rel;
    e.vec  = mkVec(code, pause, doneBit, abortedBit);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit s, input bit a, input bit h, input bit f);
    start = s;
    abort = a;
    hold  = h;
    fault = f;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
    compares++;
    if (actual !== required) begin
      mismatches++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic waitRel(input int n);
    int g = 0;
    while (cycleCount < mark + n && g < 2000) begin
      @(posedge clk);
      #2;
      g++;
    end
  endtask

  task automatic startRun();
    @(posedge clk);
    #2;
    mark = cycleCount + 1;
    applyStimulus(1, 0, 0, 0);
    @(posedge clk);
    #2;
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic waitDrain(input string name, input int limit);
    int g = 0;
    while (expQ.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    compares++;
    if (expQ.size() != 0) begin
      mismatches++;
      $display("[TB] FAIL %s_timeout actual=%0d pending required=0 pending", name, expQ.size());
      expQ.delete();
    end
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic expectFullRunHead(input string tag, input bit abortedAtStart);
    expectEv({tag, "_load"}, 0, 1, 0, 0, abortedAtStart);
    expectEv({tag, "_mix"},  4, 2, 0, 0, abortedAtStart);
  endtask

  // Monitor: compares each output change against the head of the scoreboard.
  initial begin
    logic [15:0] cur, prev;
    bit primed = 0;
    int rel;
    expEntry e;
    forever begin
      @(negedge clk);
      if (armed) begin
        cur = outVec;
        if (!primed) begin
          prev = cur;
          primed = 1;
        end else if (cur !== prev) begin
          rel = cycleCount - mark;
          compares++;
          if (expQ.size() == 0) begin
            mismatches++;
            $display("[TB] FAIL unexpected_event actual rel=%0d vec=%h required no change", rel, cur);
          end else begin
            e = expQ.pop_front();
            if (e.rel != rel || e.vec !== cur) begin
              mismatches++;
              $display("[TB] FAIL %s actual rel=%0d vec=%h required rel=%0d vec=%h",
                       e.name, rel, cur, e.rel, e.vec);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", outVec, mkVec(0, 0, 0, 0));
    armed = 1;
    repeat (3) @(posedge clk);

    $display("[TB] test 1: plain run");
    expectFullRunHead("t1", 0);
    expectEv("t1_capture",   8, 3, 0, 0, 0);
    expectEv("t1_wash_a",   12, 4, 0, 0, 0);
    expectEv("t1_antibody", 20, 5, 0, 0, 0);
    expectEv("t1_wash_b",   24, 6, 0, 0, 0);
    expectEv("t1_substrate",32, 7, 0, 0, 0);
    expectEv("t1_detect",   36, 8, 0, 0, 0);
    expectEv("t1_flush",    40, 9, 0, 0, 0);
    expectEv("t1_done",     44, 0, 0, 1, 0);
    expectEv("t1_done_end", 45, 0, 0, 0, 0);
    startRun();
    waitDrain("t1", 120);

    $display("[TB] test 2: hold in MIX");
    expectFullRunHead("t2", 0);
    expectEv("t2_hold_on",   6, 2, 1, 0, 0);
    expectEv("t2_hold_off",  9, 2, 0, 0, 0);
    expectEv("t2_capture",  11, 3, 0, 0, 0);
    expectEv("t2_wash_a",   15, 4, 0, 0, 0);
    expectEv("t2_antibody", 23, 5, 0, 0, 0);
    expectEv("t2_wash_b",   27, 6, 0, 0, 0);
    expectEv("t2_substrate",35, 7, 0, 0, 0);
    expectEv("t2_detect",   39, 8, 0, 0, 0);
    expectEv("t2_flush",    43, 9, 0, 0, 0);
    expectEv("t2_done",     47, 0, 0, 1, 0);
    expectEv("t2_done_end", 48, 0, 0, 0, 0);
    startRun();
    waitRel(5);  hold = 1'b1;
    waitRel(8);  hold = 1'b0;
    waitDrain("t2", 120);

    $display("[TB] test 3: abort in ANTIBODY");
    expectFullRunHead("t3", 0);
    expectEv("t3_capture",   8, 3, 0, 0, 0);
    expectEv("t3_wash_a",   12, 4, 0, 0, 0);
    expectEv("t3_antibody", 20, 5, 0, 0, 0);
    expectEv("t3_flush",    22, 9, 0, 0, 1);
    expectEv("t3_idle",     26, 0, 0, 0, 1);
    startRun();
    waitRel(21); abort = 1'b1;
    waitRel(22); abort = 1'b0;
    waitDrain("t3", 120);

    $display("[TB] test 4: fault in WASH_B");
    expectFullRunHead("t4", 0);
    expectEv("t4_capture",   8, 3, 0, 0, 0);
    expectEv("t4_wash_a",   12, 4, 0, 0, 0);
    expectEv("t4_antibody", 20, 5, 0, 0, 0);
    expectEv("t4_wash_b",   24, 6, 0, 0, 0);
    expectEv("t4_fault",    26, 15, 0, 0, 0);
    expectEv("t4_rst_idle", 35, 0, 0, 0, 0);
    startRun();
    waitRel(25); fault = 1'b1;
    waitRel(26); fault = 1'b0;
    waitRel(29); start = 1'b1;
    waitRel(30); start = 1'b0;
    waitRel(34); rst = 1'b1;
    waitRel(35); rst = 1'b0;
    waitDrain("t4", 120);

    $display("[TB] test 5: start while busy, abort with hold");
    expectFullRunHead("t5", 0);
    expectEv("t5_flush",  6, 9, 0, 0, 1);
    expectEv("t5_idle",  10, 0, 0, 0, 1);
    startRun();
    waitRel(1);  start = 1'b1;
    waitRel(2);  start = 1'b0;
    waitRel(5);  abort = 1'b1; hold = 1'b1;
    waitRel(6);  abort = 1'b0; hold = 1'b0;
    waitDrain("t5", 120);

    $display("[TB] test 6: reset in DETECT");
    expectFullRunHead("t6", 0);
    expectEv("t6_capture",   8, 3, 0, 0, 0);
    expectEv("t6_wash_a",   12, 4, 0, 0, 0);
    expectEv("t6_antibody", 20, 5, 0, 0, 0);
    expectEv("t6_wash_b",   24, 6, 0, 0, 0);
    expectEv("t6_substrate",32, 7, 0, 0, 0);
    expectEv("t6_detect",   36, 8, 0, 0, 0);
    expectEv("t6_rst_idle", 37, 0, 0, 0, 0);
    startRun();
    waitRel(36); rst = 1'b1;
    waitRel(37); rst = 1'b0;
    waitDrain("t6", 120);
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/hiv1_assay_sequencer.md
Name: hiv1_assay_sequencer

Overview:
- Timed state machine that runs one HIV-1 p24 immunoassay on the chip netlist: sample load, mix, capture on the trap pair, wash, antibody, wash, substrate, detect, flush.
- Drives the port-select codes of the two 4-way flow switches and the 3-way switch, plus pump (flow) and mixer enables.
- Sits between the host run controller (start/abort/hold) and the chip actuator drivers.

Parameters:
TIMER_W, 16, width of the step duration counter
T_LOAD, 64, cycles Source1 sample is pumped into Mixer1
T_MIX, 256, cycles mixer active with flow stopped
T_XFER, 32, cycles for each capture/antibody/substrate transfer to the traps
T_WASH, 48, cycles per wash pass
WASH_REPS, 2, wash passes per wash block (1..15)
T_DET, 128, cycles detection window at Out2
T_FLUSH, 64, cycles flush to Control

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  terminate run; go to FLUSH
hold  in  1  pause: timer frozen, flow_en/mix_en forced 0, selects kept
fault  in  1  pressure fault; go to FAULT
sw41_sel  out  2  flow_switch4_1 inlet: 0=Source3, 1=closed, 2=Source2, 3=Source4
sw42_sel  out  2  flow_switch4_2 inlet: 0=Source5, 1=from flow_switch4_1, 3=Source1
sw3_sel  out  2  flow_switch3_1 outlet: 1=Trap1, 2=closed, 3=Control
flow_en  out  1  pump enable
mix_en  out  1  Mixer1 enable
detect_valid  out  1  high during DETECT (not under hold)
step  out  4  current state code
busy  out  1  high in any state except IDLE and FAULT
done  out  1  one-cycle pulse on normal completion
aborted  out  1  sticky; set by abort, cleared by next accepted start

Behaviour:
- All outputs registered. Reset: IDLE, sw41=1, sw42=0, sw3=2, flow_en/mix_en/detect_valid/done/aborted/busy=0, step=0, timer=0, wash count=0.
- States (step code; sw41/sw42/sw3; flow_en, mix_en; duration):
  IDLE (0; 1/0/2; 0,0).
  LOAD (1; 1/3/3; 1,0; T_LOAD).
  MIX (2; 1/0/2; 0,1; T_MIX).
  CAPTURE (3; 1/0/1; 1,0; T_XFER).
  WASH_A (4; 1/0/1; 1,0; T_WASH x WASH_REPS).
  ANTIBODY (5; 2/1/1; 1,0; T_XFER).
  WASH_B (6; 1/0/1; 1,0; T_WASH x WASH_REPS).
  SUBSTRATE (7; 0/1/1; 1,0; T_XFER).
  DETECT (8; 3/1/1; 1,0; T_DET).
  FLUSH (9; 1/0/3; 1,0; T_FLUSH).
  FAULT (15; 1/0/2; 0,0; until rst).
- Timer: on entering a timed state it loads duration-1. It decrements each non-hold cycle. The state advances on the cycle the timer reads 0 without hold, so the state lasts exactly duration cycles, plus any hold cycles.
- Wash: counter reloads the timer WASH_REPS times; leave after the last pass.
- start in IDLE (hold low) -> LOAD next cycle; busy rises the same edge; aborted cleared. start outside IDLE is ignored.
- FLUSH end -> IDLE. done pulses in the first IDLE cycle only if no abort occurred in this run.
- abort in LOAD..DETECT -> FLUSH next cycle with a fresh T_FLUSH; aborted=1. Abort during FLUSH or IDLE is ignored.
- Priority per cycle: rst > fault > abort > hold > timer expiry. fault from any state -> FAULT; all enables 0.
- Selects change only on state transitions; no select change while flow_en=1 within a state.
- Duration parameters of 0 are illegal; assert at elaboration.

Test Plan:
1. Params T_*=4, WASH_REPS=2; start pulse -> step sequence 1,2,3,4,5,6,7,8,9,0 with lengths 4,4,4,8,4,8,4,4,4; done pulses once 44 cycles after start edge; busy high exactly 44 cycles.
2. hold for 3 cycles mid-MIX -> mix_en=0 during hold; MIX lasts 7 cycles; selects unchanged; total run 47 cycles.
3. abort in ANTIBODY -> next cycle step=9, sw3=3, sw42=0; 4 cycles later IDLE; aborted=1, no done pulse; next start clears aborted.
4. fault during WASH_B -> step=15, flow_en=0, busy=0; start ignored; only rst returns to IDLE with reset outputs.
5. start while busy and abort+hold together -> start ignored; abort wins, FLUSH entered, timer reloaded to T_FLUSH-1.
6. rst asserted mid-DETECT -> next cycle all outputs at reset values, detect_valid=0, no done pulse.
